// File: rtl/fir_mac_sequencer_if.sv
// Handshake, coefficient-load and result bus for the time-multiplexed FIR.
// The producer/consumer side uses master; the FIR block itself uses slave.
interface fir_mac_sequencer_if #(
  parameter int TAPS = 8,
  parameter int DW   = 8,
  parameter int CW   = 8,
  parameter int OW   = 16
);
  localparam int KW = $clog2(TAPS);

  logic                 in_valid;
  logic                 in_ready;
  logic signed [DW-1:0] in_data;
  logic                 coef_we;
  logic [KW-1:0]        coef_addr;
  logic signed [CW-1:0] coef_data;
  logic                 out_valid;
  logic signed [OW-1:0] out_data;
  logic                 busy;

  modport master (
    output in_valid, in_data, coef_we, coef_addr, coef_data,
    input  in_ready, out_valid, out_data, busy
  );

  modport slave (
    input  in_valid, in_data, coef_we, coef_addr, coef_data,
    output in_ready, out_valid, out_data, busy
  );
endinterface

// File: rtl/fir_mac_sequencer.sv
// N-tap signed FIR built around one multiply-accumulate step per clock.
// Samples enter a circular delay line; each result is saturated to OW bits.
module fir_mac_sequencer #(
  parameter int TAPS  = 8,
  parameter int DW    = 8,
  parameter int CW    = 8,
  parameter int OW    = 16,
  parameter int SHIFT = 0
) (
  input  logic             clk,
  input  logic             rst_n,
  fir_mac_sequencer_if.slave bus
);
  localparam int KW = $clog2(TAPS);
  localparam int PW = DW + CW;
  localparam int AW = PW + KW;
  localparam int SW = (AW > OW) ? AW : OW + 1;

  localparam logic [KW-1:0]        K_LAST  = KW'(TAPS - 1);
  localparam logic signed [SW-1:0] SAT_MAX = {{(SW-OW+1){1'b0}}, {(OW-1){1'b1}}};
  localparam logic signed [SW-1:0] SAT_MIN = {{(SW-OW+1){1'b1}}, {(OW-1){1'b0}}};

  typedef enum logic {IDLE, MAC} state_t;

  state_t               state;
  logic signed [DW-1:0] delay_line [TAPS];
  logic signed [CW-1:0] coef       [TAPS];
  logic [KW-1:0]        wp;
  logic [KW-1:0]        newest;
  logic [KW-1:0]        k;
  logic signed [AW-1:0] acc;
  logic                 in_ready_q;
  logic                 busy_q;
  logic                 out_valid_q;
  logic signed [OW-1:0] out_data_q;

  logic                 accept;
  logic [KW-1:0]        rd_idx;
  logic signed [PW-1:0] product;
  logic signed [AW-1:0] acc_next;
  logic signed [AW-1:0] acc_shifted;
  logic signed [SW-1:0] acc_wide;
  logic signed [OW-1:0] sat_result;

  assign accept = bus.in_valid & in_ready_q;

  // TAPS is a power of two, so the KW-bit subtraction wraps modulo TAPS.
  assign rd_idx      = newest - k;
  assign product     = delay_line[rd_idx] * coef[k];
  assign acc_next    = acc + {{KW{product[PW-1]}}, product};
  assign acc_shifted = acc_next >>> SHIFT;
  assign acc_wide    = SW'(acc_shifted);

  always_comb begin
    sat_result = acc_wide[OW-1:0];
    if (acc_wide > SAT_MAX) begin
      sat_result = {1'b0, {(OW-1){1'b1}}};
    end else if (acc_wide < SAT_MIN) begin
      sat_result = {1'b1, {(OW-1){1'b0}}};
    end
  end

  // Control, delay line, coefficient file and result register share one process
  // so an asynchronous reset clears everything together, mid-computation included.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state       <= IDLE;
      in_ready_q  <= 1'b1;
      busy_q      <= 1'b0;
      out_valid_q <= 1'b0;
      out_data_q  <= '0;
      wp          <= '0;
      newest      <= '0;
      k           <= '0;
      acc         <= '0;
      for (int i = 0; i < TAPS; i++) begin
        delay_line[i] <= '0;
        coef[i]       <= '0;
      end
    end else begin
      out_valid_q <= 1'b0;
      case (state)
        IDLE: begin
          if (bus.coef_we) begin
            coef[bus.coef_addr] <= bus.coef_data;
          end
          if (accept) begin
            delay_line[wp] <= bus.in_data;
            newest         <= wp;
            wp             <= wp + 1'b1;
            acc            <= '0;
            k              <= '0;
            state          <= MAC;
            in_ready_q     <= 1'b0;
            busy_q         <= 1'b1;
          end
        end
        MAC: begin
          acc <= acc_next;
          k   <= k + 1'b1;
          if (k == K_LAST) begin
            out_data_q  <= sat_result;
            out_valid_q <= 1'b1;
            state       <= IDLE;
            in_ready_q  <= 1'b1;
            busy_q      <= 1'b0;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign bus.in_ready  = in_ready_q;
  assign bus.busy      = busy_q;
  assign bus.out_valid = out_valid_q;
  assign bus.out_data  = out_data_q;
endmodule

// File: tb/tb_fir_mac_sequencer.sv
// Directed bench for fir_mac_sequencer: reset, impulse response, saturation,
// backpressure, coefficient-write timing and reset during a computation.
module tb_fir_mac_sequencer;
  localparam int TAPS = 8;

  logic clk   = 1'b0;
  logic rst_n = 1'b0;
  int   checks = 0;
  int   errors = 0;

  int m_delay [TAPS];
  int m_coef  [TAPS];
  int m_wp;

  fir_mac_sequencer_if #(.TAPS(TAPS), .DW(8), .CW(8), .OW(16)) bus ();

  fir_mac_sequencer #(.TAPS(TAPS), .DW(8), .CW(8), .OW(16), .SHIFT(0)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic checkOutput(input string tag, input logic signed [31:0] observed,
                             input logic signed [31:0] expected);
    checks++;
    assert (observed === expected) else begin
      errors++;
      $error("[TB] FAIL %s: observed %0d expected %0d", tag, observed, expected);
    end
  endtask

  function automatic int sat16(input int v);
    if (v > 32767) return 32767;
    if (v < -32768) return -32768;
    return v;
  endfunction

  // Reference FIR: pushes one sample and returns the saturated response.
  function automatic int model_push(input int s);
    int newest;
    int sum;
    m_delay[m_wp] = s;
    newest = m_wp;
    m_wp = (m_wp + 1) % TAPS;
    sum = 0;
    for (int j = 0; j < TAPS; j++) begin
      sum += m_delay[(newest - j + TAPS) % TAPS] * m_coef[j];
    end
    return sat16(sum);
  endfunction

  task automatic do_reset();
    rst_n         = 1'b0;
    bus.in_valid  = 1'b0;
    bus.in_data   = '0;
    bus.coef_we   = 1'b0;
    bus.coef_addr = '0;
    bus.coef_data = '0;
    tick();
    tick();
    rst_n = 1'b1;
  endtask

  task automatic load_coef(input int k, input int value);
    bus.coef_we   = 1'b1;
    bus.coef_addr = 3'(k);
    bus.coef_data = 8'(value);
    tick();
    bus.coef_we = 1'b0;
  endtask

  task automatic wait_result(output logic signed [31:0] result, output int cycles);
    cycles = 0;
    while (!bus.out_valid && cycles < 20) begin
      tick();
      cycles++;
    end
    result = bus.out_data;
  endtask

  task automatic applyStimulus(input logic signed [7:0] sample,
                               output logic signed [31:0] result, output int latency);
    int waited = 0;
    bus.in_valid = 1'b1;
    bus.in_data  = sample;
    while (!bus.in_ready && waited < 20) begin
      tick();
      waited++;
    end
    if (!bus.in_ready) checkOutput("accept timeout", bus.in_ready, 1);
    tick();
    bus.in_valid = 1'b0;
    wait_result(result, latency);
  endtask

  task automatic run_and_check(input string tag, input int sample, input int expected);
    logic signed [31:0] result;
    int latency;
    applyStimulus(8'(sample), result, latency);
    checkOutput({tag, " data"}, result, expected);
    checkOutput({tag, " latency"}, latency, TAPS);
  endtask

  // With coefficients cleared every result is 0; the trailing zeros also flush the delay line.
  task automatic run_zero_flush(input string tag, input int first_sample);
    run_and_check(tag, first_sample, 0);
    for (int i = 0; i < TAPS - 1; i++) run_and_check(tag, 0, 0);
  endtask

  // Coefficients 1..8 and a unit impulse: responses 1,2,...,8 then 0.
  task automatic run_tap_sweep(input string tag);
    for (int i = 0; i < TAPS; i++) load_coef(i, i + 1);
    for (int i = 0; i <= TAPS; i++) begin
      run_and_check(tag, (i == 0) ? 1 : 0, (i < TAPS) ? i + 1 : 0);
    end
  endtask

  initial begin
    logic signed [31:0] result;
    int cycles;
    int low;
    int prev_exp;
    int pulses;
    int bp_coef [TAPS];
    int bp_seq  [6];
    bp_coef = '{3, -2, 5, -7, 1, 0, 4, -1};
    bp_seq  = '{10, -20, 100, -128, 127, -1};

    bus.in_valid  = 1'b0;
    bus.in_data   = '0;
    bus.coef_we   = 1'b0;
    bus.coef_addr = '0;
    bus.coef_data = '0;

    $display("[TB] reset");
    tick();
    checkOutput("reset in_ready", bus.in_ready, 1);
    checkOutput("reset busy", bus.busy, 0);
    checkOutput("reset out_valid", bus.out_valid, 0);
    checkOutput("reset out_data", bus.out_data, 0);
    rst_n = 1'b1;
    tick();
    checkOutput("post-reset in_ready", bus.in_ready, 1);
    run_zero_flush("unloaded", 55);

    $display("[TB] impulse");
    run_tap_sweep("impulse");

    $display("[TB] saturation");
    for (int i = 0; i < TAPS; i++) load_coef(i, 127);
    for (int n = 1; n <= TAPS; n++) run_and_check("sat pos", 127, sat16(n * 16129));
    for (int n = 1; n <= TAPS; n++) run_and_check("sat flush", 0, sat16((TAPS - n) * 16129));
    for (int n = 1; n <= TAPS; n++) run_and_check("sat neg", -128, sat16(-n * 16256));

    $display("[TB] backpressure");
    do_reset();
    for (int i = 0; i < TAPS; i++) begin
      load_coef(i, bp_coef[i]);
      m_coef[i]  = bp_coef[i];
      m_delay[i] = 0;
    end
    m_wp = 0;
    prev_exp = 0;
    bus.in_valid = 1'b1;
    for (int i = 0; i < 6; i++) begin
      bus.in_data = 8'(bp_seq[i]);
      low = 0;
      while (!bus.in_ready && low < 20) begin
        tick();
        low++;
      end
      if (i > 0) begin
        checkOutput("bp ready low cycles", low, TAPS);
        checkOutput("bp out_valid at accept", bus.out_valid, 1);
        checkOutput("bp result", bus.out_data, prev_exp);
      end
      prev_exp = model_push(bp_seq[i]);
      tick();
    end
    bus.in_valid = 1'b0;
    wait_result(result, cycles);
    checkOutput("bp last result", result, prev_exp);
    checkOutput("bp last latency", cycles, TAPS);

    $display("[TB] coefficient write during MAC");
    bus.in_valid = 1'b1;
    bus.in_data  = 8'sd50;
    tick();
    bus.in_valid = 1'b0;
    prev_exp = model_push(50);
    tick();
    bus.coef_we   = 1'b1;
    bus.coef_addr = 3'd0;
    bus.coef_data = 8'sd99;
    tick();
    bus.coef_we = 1'b0;
    wait_result(result, cycles);
    checkOutput("mac coef_we result", result, prev_exp);
    run_and_check("mac coef_we next", 25, model_push(25));

    $display("[TB] coefficient write with acceptance");
    do_reset();
    bus.coef_we   = 1'b1;
    bus.coef_addr = 3'd0;
    bus.coef_data = 8'sd5;
    bus.in_valid  = 1'b1;
    bus.in_data   = 8'sd1;
    tick();
    bus.coef_we  = 1'b0;
    bus.in_valid = 1'b0;
    wait_result(result, cycles);
    checkOutput("same-edge coef result", result, 5);
    checkOutput("same-edge coef latency", cycles, TAPS);

    $display("[TB] reset mid-MAC");
    for (int i = 0; i < TAPS; i++) load_coef(i, i + 1);
    bus.in_valid = 1'b1;
    bus.in_data  = 8'sd9;
    tick();
    bus.in_valid = 1'b0;
    tick();
    tick();
    tick();
    checkOutput("mid-MAC busy before reset", bus.busy, 1);
    rst_n = 1'b0;
    #1;
    checkOutput("abort busy", bus.busy, 0);
    checkOutput("abort in_ready", bus.in_ready, 1);
    checkOutput("abort out_valid", bus.out_valid, 0);
    checkOutput("abort out_data", bus.out_data, 0);
    tick();
    rst_n = 1'b1;
    pulses = 0;
    for (int i = 0; i < 12; i++) begin
      tick();
      if (bus.out_valid) pulses++;
    end
    checkOutput("abort out_valid pulses", pulses, 0);
    run_zero_flush("post-abort", 1);
    run_tap_sweep("post-abort impulse");

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
